// File: rtl/axi4lite_uart_tx.sv
// axi4lite_uart_tx
// AXI4-Lite responder for the console UART window. Writes push a byte into a
// small TX FIFO, reads return a status word, and an 8N1 serializer drains the
// FIFO onto the tx line at CLK_DIV clock cycles per bit.
//
// Status word layout:
//   [0]    FIFO full
//   [1]    FIFO empty
//   [2]    serializer busy (state is not IDLE)
//   [15:8] FIFO count
//   others zero

module axi4lite_uart_tx #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  // read address / data
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  // write address / data / response
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] wstrb,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            bresp,
  // serial line
  output logic                  tx
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } ser_state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                  rvalid_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic                  bvalid_r;
  logic                  aw_got_r;
  logic                  w_got_r;

  logic [7:0]            mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;

  ser_state_t            state_r;
  logic [TMR_W-1:0]      timer_r;
  logic [2:0]            bit_cnt_r;
  logic [7:0]            shift_r;
  logic                  tx_r;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic                  ar_hs_s;
  logic                  aw_hs_s;
  logic                  w_hs_s;
  logic                  aw_have_s;
  logic                  w_have_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  full_s;
  logic                  empty_s;
  logic                  busy_s;
  logic                  timer_last_s;
  logic [7:0]            head_s;
  logic [DATA_WIDTH-1:0] status_s;
  logic                  unused_s;

  // Addresses and the upper data/strobe bits carry no meaning for this window.
  assign unused_s = ^{araddr, awaddr, wdata[DATA_WIDTH-1:8], wstrb[DATA_WIDTH-1:1]};

  // Ready signals follow directly from the channel state registers.
  assign arready = !rvalid_r;
  assign awready = !aw_got_r && !bvalid_r;
  assign wready  = !w_got_r && !bvalid_r && !full_s;

  assign rvalid  = rvalid_r;
  assign rdata   = rdata_r;
  assign rresp   = 2'b00;
  assign bvalid  = bvalid_r;
  assign bresp   = 2'b00;
  assign tx      = tx_r;

  assign head_s  = mem_r[rd_ptr_r];

  // Handshakes, FIFO flags, push qualification and the status word.
  always_comb begin
    ar_hs_s      = arvalid && arready;
    aw_hs_s      = awvalid && awready;
    w_hs_s       = wvalid && wready;
    aw_have_s    = aw_got_r || aw_hs_s;
    w_have_s     = w_got_r || w_hs_s;
    full_s       = (count_r == CNT_FULL);
    empty_s      = (count_r == CNT_ZERO);
    busy_s       = (state_r != ST_IDLE);
    timer_last_s = (timer_r == TMR_LAST);
    push_s       = w_hs_s && wstrb[0];

    status_s              = {DATA_WIDTH{1'b0}};
    status_s[0]           = full_s;
    status_s[1]           = empty_s;
    status_s[2]           = busy_s;
    status_s[8 +: CNT_W]  = count_r;
  end

  // Pop whenever the serializer is ready to take a new byte and one is queued.
  always_comb begin
    pop_s = 1'b0;
    if (empty_s) begin
      pop_s = 1'b0;
    end else if (state_r == ST_IDLE) begin
      pop_s = 1'b1;
    end else if ((state_r == ST_STOP) && timer_last_s) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel: sample status on AR, hold until the R handshake completes.
  // ---------------------------------------------------------------------------
  // Read response register: one outstanding read, data frozen while rvalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_r <= 1'b0;
      rdata_r  <= {DATA_WIDTH{1'b0}};
    end else if (ar_hs_s) begin
      rvalid_r <= 1'b1;
      rdata_r  <= status_s;
    end else if (rvalid_r && rready) begin
      rvalid_r <= 1'b0;
      rdata_r  <= rdata_r;
    end else begin
      rvalid_r <= rvalid_r;
      rdata_r  <= rdata_r;
    end
  end

  // ---------------------------------------------------------------------------
  // Write channel: AW and W collected independently, B issued once both held.
  // ---------------------------------------------------------------------------
  // Write beat tracking and write response generation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_got_r <= 1'b0;
      w_got_r  <= 1'b0;
      bvalid_r <= 1'b0;
    end else if (aw_have_s && w_have_s) begin
      // Ready signals are gated by bvalid, so this cannot coincide with a
      // pending response.
      aw_got_r <= 1'b0;
      w_got_r  <= 1'b0;
      bvalid_r <= 1'b1;
    end else begin
      aw_got_r <= aw_have_s;
      w_got_r  <= w_have_s;
      if (bvalid_r && bready) begin
        bvalid_r <= 1'b0;
      end else begin
        bvalid_r <= bvalid_r;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wdata[7:0];
    end
  end

  // FIFO pointers and occupancy count; pointers wrap modulo FIFO_DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Serializer: IDLE -> START -> DATA (8 bits, LSB first) -> STOP.
  // tx is registered from the current state, so the line lags the state by one
  // clock and every bit still lasts exactly CLK_DIV cycles.
  // ---------------------------------------------------------------------------
  // 8N1 serializer state machine with registered tx output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      timer_r   <= TMR_ZERO;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'd0;
      tx_r      <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          tx_r      <= 1'b1;
          timer_r   <= TMR_ZERO;
          bit_cnt_r <= 3'd0;
          if (pop_s) begin
            shift_r <= head_s;
            state_r <= ST_START;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_START: begin
          tx_r <= 1'b0;
          if (timer_last_s) begin
            timer_r   <= TMR_ZERO;
            bit_cnt_r <= 3'd0;
            state_r   <= ST_DATA;
          end else begin
            timer_r <= timer_r + TMR_ONE;
          end
        end

        ST_DATA: begin
          tx_r <= shift_r[0];
          if (timer_last_s) begin
            timer_r <= TMR_ZERO;
            shift_r <= {1'b0, shift_r[7:1]};
            if (bit_cnt_r == 3'd7) begin
              bit_cnt_r <= 3'd0;
              state_r   <= ST_STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end else begin
            timer_r <= timer_r + TMR_ONE;
          end
        end

        ST_STOP: begin
          tx_r <= 1'b1;
          if (timer_last_s) begin
            timer_r <= TMR_ZERO;
            if (pop_s) begin
              // Next byte already queued: chain straight into a new start bit.
              shift_r <= head_s;
              state_r <= ST_START;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            timer_r <= timer_r + TMR_ONE;
          end
        end

        default: begin
          tx_r      <= 1'b1;
          timer_r   <= TMR_ZERO;
          bit_cnt_r <= 3'd0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_uart_tx.sv
// tb_axi4lite_uart_tx
// Scoreboard bench: bytes written are queued as expected tx frames and compared
// when the line monitor decodes a frame; expected status words are queued per
// read and compared when the R beat appears.

module tb_axi4lite_uart_tx;

  localparam int DIV  = 4;
  localparam int HALF = DIV / 2;

  logic        clk;
  logic        rst;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [31:0] wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        tx;

  int          n_checks;
  int          n_fail;
  int          cyc;
  int          frames_seen;
  int          w_hs_cyc;
  int          aw_hs_cyc;
  int          start_cyc_q[$];
  logic [7:0]  sb_q[$];
  logic [31:0] rd_q[$];

  logic [7:0]  mon_byte;
  logic        mon_abort;
  logic        mon_start;
  logic        mon_stop;

  axi4lite_uart_tx #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .FIFO_DEPTH (4),
    .CLK_DIV    (DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .arvalid (arvalid),
    .arready (arready),
    .araddr  (araddr),
    .rvalid  (rvalid),
    .rready  (rready),
    .rdata   (rdata),
    .rresp   (rresp),
    .awvalid (awvalid),
    .awready (awready),
    .awaddr  (awaddr),
    .wvalid  (wvalid),
    .wready  (wready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .bvalid  (bvalid),
    .bready  (bready),
    .bresp   (bresp),
    .tx      (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter: value N is visible after the N-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Line monitor: decode 8N1 frames sampled mid-bit on falling clock edges.
  initial begin
    frames_seen = 0;
    forever begin
      @(negedge clk);
      if (!rst && tx == 1'b0) begin
        mon_abort = 1'b0;
        mon_start = 1'b1;
        mon_stop  = 1'b0;
        mon_byte  = 8'h00;
        start_cyc_q.push_back(cyc);
        for (int c = 1; c < 10 * DIV; c++) begin
          @(negedge clk);
          if (rst) mon_abort = 1'b1;
          if (mon_abort) break;
          if (c == HALF) mon_start = tx;
          if (c >= HALF + DIV && c < HALF + 9 * DIV && ((c - HALF) % DIV) == 0)
            mon_byte[(c - HALF) / DIV - 1] = tx;
          if (c == HALF + 9 * DIV) mon_stop = tx;
        end
        if (!mon_abort) begin
          frames_seen++;
          check_val("start_bit", {31'd0, mon_start}, 32'd0);
          check_val("stop_bit", {31'd0, mon_stop}, 32'd1);
          check_val("frame_expected", {31'd0, (sb_q.size() > 0)}, 32'd1);
          if (sb_q.size() > 0) check_val("tx_byte", {24'd0, mon_byte}, {24'd0, sb_q.pop_front()});
        end
      end
    end
  end

  // Issue one write; W may lag AW by w_delay cycles. Called at a falling edge.
  task automatic axi_write(input logic [7:0] d, input logic s0, input int w_delay);
    int   t;
    logic aw_done;
    logic w_done;
    logic hs_aw;
    logic hs_w;
    if (s0) sb_q.push_back(d);
    awvalid = 1'b1;
    wvalid  = (w_delay == 0);
    wdata   = {24'h5A5A5A, d};
    wstrb   = {31'd0, s0};
    aw_done = 1'b0;
    w_done  = 1'b0;
    t = 0;
    while (!(aw_done && w_done) && t < 200) begin
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(negedge clk);
      t++;
      if (hs_aw) begin aw_done = 1'b1; awvalid = 1'b0; aw_hs_cyc = cyc; end
      if (hs_w)  begin w_done  = 1'b1; wvalid  = 1'b0; w_hs_cyc  = cyc; end
      if (!w_done && t >= w_delay) wvalid = 1'b1;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check_val("write_accepted", {31'd0, (aw_done && w_done)}, 32'd1);
    check_val("bvalid_latency", {31'd0, bvalid}, 32'd1);
    check_val("bresp", {30'd0, bresp}, 32'd0);
    @(negedge clk);
    check_val("bvalid_clear", {31'd0, bvalid}, 32'd0);
  endtask

  // Issue one read expecting status exp; rready held low for hold cycles.
  task automatic axi_read(input logic [31:0] exp, input int hold);
    int          t;
    logic [31:0] want;
    rd_q.push_back(exp);
    arvalid = 1'b1;
    rready  = (hold == 0);
    t = 0;
    while (!arready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_val("arready", {31'd0, arready}, 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    want = rd_q.pop_front();
    check_val("rvalid_latency", {31'd0, rvalid}, 32'd1);
    check_val("rresp", {30'd0, rresp}, 32'd0);
    check_val("rdata", rdata, want);
    check_val("arready_busy", {31'd0, arready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val("rvalid_hold", {31'd0, rvalid}, 32'd1);
      check_val("rdata_hold", rdata, want);
      check_val("arready_hold", {31'd0, arready}, 32'd0);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check_val("rvalid_clear", {31'd0, rvalid}, 32'd0);
    check_val("arready_back", {31'd0, arready}, 32'd1);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int t;
    t = 0;
    while (frames_seen < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    check_val("frames_done", frames_seen, target);
  endtask

  initial begin
    int base;
    int lat;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    arvalid  = 1'b0;
    araddr   = 32'ha000_03f8;
    rready   = 1'b0;
    awvalid  = 1'b0;
    awaddr   = 32'ha000_03f8;
    wvalid   = 1'b0;
    wdata    = 32'd0;
    wstrb    = 32'd0;
    bready   = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_tx", {31'd0, tx}, 32'd1);
    check_val("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check_val("rst_bvalid", {31'd0, bvalid}, 32'd0);
    check_val("rst_rdata", rdata, 32'd0);
    check_val("rst_rresp", {30'd0, rresp}, 32'd0);
    check_val("rst_bresp", {30'd0, bresp}, 32'd0);
    check_val("rst_ready", {29'd0, arready, awready, wready}, 32'd7);
    rst = 1'b0;
    @(negedge clk);

    // 1: status read after reset
    axi_read(32'h0000_0002, 0);
    check_val("idle_tx", {31'd0, tx}, 32'd1);

    // 2: single byte, AW one cycle ahead of W
    start_cyc_q.delete();
    base = frames_seen;
    axi_write(8'h55, 1'b1, 1);
    check_val("w_after_aw", w_hs_cyc - aw_hs_cyc, 32'd1);
    wait_frames(base + 1, 100);
    lat = (start_cyc_q.size() > 0) ? (start_cyc_q[0] - w_hs_cyc) : -1;
    check_val("tx_fall_latency", lat, 32'd2);

    // 3: fill FIFO, check full status, then drain six back-to-back frames
    repeat (5) @(negedge clk);
    start_cyc_q.delete();
    base = frames_seen;
    for (int i = 0; i < 5; i++) axi_write(8'h41 + 8'(i), 1'b1, 0);
    check_val("wready_full", {31'd0, wready}, 32'd0);
    axi_read(32'h0000_0405, 0);
    axi_write(8'h46, 1'b1, 0);
    wait_frames(base + 6, 6 * 10 * DIV + 100);
    check_val("frames_t3", start_cyc_q.size(), 32'd6);
    for (int i = 1; i < start_cyc_q.size(); i++)
      check_val("frame_gap", start_cyc_q[i] - start_cyc_q[i-1], 10 * DIV);

    // 4: read backpressure
    repeat (3) @(negedge clk);
    axi_read(32'h0000_0002, 5);

    // 5: write with empty strobe pushes nothing
    base = frames_seen;
    axi_write(8'hAA, 1'b0, 0);
    repeat (60) @(negedge clk);
    check_val("no_frame_strobe0", frames_seen, base);
    axi_read(32'h0000_0002, 0);

    // 6: reset in the middle of a frame with two bytes queued
    axi_write(8'h00, 1'b1, 0);
    axi_write(8'h5A, 1'b1, 0);
    axi_write(8'hA5, 1'b1, 0);
    repeat (10) @(negedge clk);
    check_val("mid_frame_low", {31'd0, tx}, 32'd0);
    #1 rst = 1'b1;
    #1;
    check_val("rst_tx_immediate", {31'd0, tx}, 32'd1);
    check_val("rst_rvalid_mid", {31'd0, rvalid}, 32'd0);
    check_val("rst_bvalid_mid", {31'd0, bvalid}, 32'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base = frames_seen;
    axi_read(32'h0000_0002, 0);
    repeat (100) @(negedge clk);
    check_val("no_frame_after_rst", frames_seen, base);
    check_val("tx_idle_end", {31'd0, tx}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog keeps the run bounded.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi4lite_uart_tx.md
# axi4lite_uart_tx

AXI4-Lite responder for the console UART window (0xa000_03f8–0xa000_03fb) that sits on the UART port of the NPC AXI4-Lite crossbar. Writes push a byte into a small TX FIFO, and reads return a status word. A serializer drains the FIFO onto a single 8N1 serial line at CLK_DIV clock cycles per bit.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; wstrb is also DATA_WIDTH wide to match the crossbar
- FIFO_DEPTH, 4, TX FIFO entries; power of two, ≥2
- CLK_DIV, 16, clock cycles per serial bit; ≥2
- clk  input  1  clock; everything is synchronous to its rising edge
- rst  input  1  asynchronous, active-high reset
- arvalid/arready  in/out  1  read address handshake
- araddr  input  ADDR_WIDTH  ignored; single register
- rvalid/rready  out/in  1  read data handshake
- rdata  output  DATA_WIDTH  status word
- rresp  output  2  always 2'b00
- awvalid/awready  in/out  1  write address handshake
- awaddr  input  ADDR_WIDTH  ignored
- wvalid/wready  in/out  1  write data handshake
- wdata  input  DATA_WIDTH  byte in [7:0]
- wstrb  input  DATA_WIDTH  only bit 0 used
- bvalid/bready  out/in  1  write response handshake
- bresp  output  2  always 2'b00
- tx  output  1  serial line, idle high

## Operation
- **Reset values:**
  - tx=1, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0
  - FIFO empty, serializer IDLE
  - arready=awready=wready=1
- **Status word:**
  - bit0 = FIFO full
  - bit1 = FIFO empty
  - bit2 = serializer busy (state ≠ IDLE)
  - bits[15:8] = FIFO count
  - all other bits 0
- **Read channel:**
  - arready = !rvalid.
  - On AR handshake, the status is sampled and registered into rdata, and rvalid is set the next cycle.
  - rvalid and rdata hold stable until rready; rvalid clears on the cycle after the R handshake.
  - At most one read is outstanding.
- **Write channel:** AW and W are accepted independently, in either order or in the same cycle.
  - aw_got / w_got flags record the accepted beats.
  - awready = !aw_got && !bvalid.
  - wready = !w_got && !bvalid && !full.
- **FIFO push:** happens on the W handshake when wstrb[0]=1, storing wdata[7:0]. When wstrb[0]=0 the beat is accepted but nothing is pushed.
- **Write response:**
  - When both beats are held (including those handshaking this cycle), bvalid is set next cycle, and aw_got/w_got clear.
  - bvalid holds until bready.
- **FIFO:** circular buffer with read/write pointers, count width $clog2(FIFO_DEPTH)+1.
  - Full and empty are derived from count.
  - Push and pop in the same cycle leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- **Serializer FSM:** IDLE → START → DATA → STOP.
  - IDLE: tx=1. If the FIFO is not empty, pop into the shift register and go to START.
  - START: tx=0 for CLK_DIV cycles.
  - DATA: 8 bits, LSB first, CLK_DIV cycles each; a 3-bit bit counter is used.
  - STOP: tx=1 for CLK_DIV cycles. At the end of STOP, if the FIFO is not empty, pop and go directly to START; otherwise go to IDLE.
  - A bit timer counts 0..CLK_DIV-1.
  - tx is a registered output.
- **Reset mid-operation:**
  - Any frame in flight is aborted and tx goes to 1 immediately.
  - FIFO contents and pending R/B responses are discarded.

## Timing
- Read latency: rvalid is high 1 cycle after the AR handshake.
- Write response latency: bvalid is high 1 cycle after the later of the AW and W handshakes.
- Serializer start, FIFO empty and IDLE, W handshake at edge N:
  - FIFO is non-empty after edge N.
  - Pop occurs at edge N+1.
  - tx falls after edge N+2.
- Frame length is exactly 10×CLK_DIV cycles. Back-to-back frames have no idle gap.
- Full boundary: wready drops the cycle after the push that makes count=FIFO_DEPTH. It rises the cycle after the next pop.
- A pop and an AR in the same cycle: the status reflects the pre-edge count.

## Test plan
1. **Reset status read:** reset, then AR → next-cycle rvalid=1, rdata=0x0000_0002, rresp=0; tx=1 throughout.
2. **Single byte, CLK_DIV=4:**
   - Stimulus: AW cycle 0, W cycle 1 with wdata=0x55, wstrb=1.
   - Response: bvalid at cycle 2, bresp=0.
   - tx: low from cycle 3 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4 cycles; 40 cycles total.
3. **FIFO full (FIFO_DEPTH=4, CLK_DIV=4):**
   - Stimulus: write 0x41..0x46 back to back.
   - Response: after the fifth accepted write, wready=0 and a status read shows bit0=1 and count=4.
   - Bytes emerge on tx as 0x41..0x46 in order.
4. **Read backpressure:** AR, then rready held low 5 cycles → rvalid and rdata stable, arready=0; R handshake on cycle 6, then rvalid=0 and arready=1.
5. **Empty strobe:** wstrb=0, wdata=0xAA → bvalid with bresp=0; no frame on tx; count stays 0.
6. **Reset mid-frame:** assert rst during DATA with 2 bytes queued → tx=1 immediately; after release, status=0x0000_0002 and no further frames.
